// File: rtl/trap_if.sv
// Bus between the core and the trap controller: execute-stage qualifiers and
// CSR file contents flow in; CSR writes, stall and PC redirect flow out.
interface trap_if;
  logic [31:0] pc;
  logic        mret;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        csr_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Core side: drives pipeline/CSR state, receives trap actions
  modport master (
    output pc, mret, csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
    input  csr_wr, csr_addr, csr_wdata, stall, redirect, redirect_pc
  );

  // Trap controller side
  modport slave (
    input  pc, mret, csr_mstatus, csr_mie, csr_mtvec, csr_mepc,
    output csr_wr, csr_addr, csr_wdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: synchronises external/timer interrupts,
// sequences trap entry (mepc, mcause, mstatus writes then vector jump) and
// MRET return (mstatus restore then jump to mepc), stalling the pipeline.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   irq_ext,
  input  logic   irq_timer,
  trap_if.slave  bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned CW   = 4;

  localparam logic [AW-1:0] ADDR_MSTATUS = AW'(12'h300);
  localparam logic [AW-1:0] ADDR_MEPC    = AW'(12'h341);
  localparam logic [AW-1:0] ADDR_MCAUSE  = AW'(12'h342);
  localparam logic [CW-1:0] CAUSE_EXT    = CW'(11);
  localparam logic [CW-1:0] CAUSE_TMR    = CW'(7);

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STAT, T_JMP, R_STAT, R_JMP
  } state_t;

  state_t            state_q, state_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, tmr_sync_q;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CW-1:0]     cause_q, cause_d;

  logic              wr_d, stall_d, redir_d;
  logic [AW-1:0]     addr_d;
  logic [XLEN-1:0]   wdata_d, rpc_d;

  logic              ext_en, tmr_en, pending;
  logic [XLEN-1:0]   mstatus_trap, mstatus_ret, vec_base, vec_target;
  logic              unused_mie;

  // Interrupt synchronisers; only the last stage is ever observed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync_q <= '0;
      tmr_sync_q <= '0;
    end else begin
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], irq_ext};
      tmr_sync_q <= {tmr_sync_q[SYNC_STAGES-2:0], irq_timer};
    end
  end

  assign ext_en  = ext_sync_q[SYNC_STAGES-1] & bus.csr_mie[11];
  assign tmr_en  = tmr_sync_q[SYNC_STAGES-1] & bus.csr_mie[7];
  assign pending = (ext_en | tmr_en) & bus.csr_mstatus[3];

  assign unused_mie = ^{bus.csr_mie[31:12], bus.csr_mie[10:8], bus.csr_mie[6:0]};

  // Entry saves MIE into MPIE and disables; return restores MIE and sets MPIE
  assign mstatus_trap = {bus.csr_mstatus[31:8], bus.csr_mstatus[3],
                         bus.csr_mstatus[6:4], 1'b0, bus.csr_mstatus[2:0]};
  assign mstatus_ret  = {bus.csr_mstatus[31:8], 1'b1,
                         bus.csr_mstatus[6:4], bus.csr_mstatus[7], bus.csr_mstatus[2:0]};

  assign vec_base   = {bus.csr_mtvec[XLEN-1:2], 2'b00};
  assign vec_target = (bus.csr_mtvec[1:0] == 2'b01)
                    ? vec_base + {{(XLEN-CW-2){1'b0}}, cause_q, 2'b00}
                    : vec_base;

  // State, latched PC and cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  // Next state, plus outputs decoded from the next state so that the
  // registered outputs line up with the cycle the FSM sits in that state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    stall_d = 1'b1;
    redir_d = 1'b0;
    rpc_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.mret) begin
          state_d = R_STAT;
        end else if (pending) begin
          state_d = T_EPC;
          pc_d    = bus.pc;
          cause_d = ext_en ? CAUSE_EXT : CAUSE_TMR;
        end
      end
      T_EPC:   state_d = T_CAUSE;
      T_CAUSE: state_d = T_STAT;
      T_STAT:  state_d = T_JMP;
      T_JMP:   state_d = IDLE;
      R_STAT:  state_d = R_JMP;
      R_JMP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      IDLE: stall_d = 1'b0;
      T_EPC: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_MEPC;
        wdata_d = pc_d;
      end
      T_CAUSE: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_MCAUSE;
        wdata_d = {1'b1, {(XLEN-CW-1){1'b0}}, cause_q};
      end
      T_STAT, R_STAT: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_MSTATUS;
        wdata_d = (state_d == T_STAT) ? mstatus_trap : mstatus_ret;
      end
      T_JMP: begin
        redir_d = 1'b1;
        rpc_d   = vec_target;
      end
      R_JMP: begin
        redir_d = 1'b1;
        rpc_d   = bus.csr_mepc;
      end
      default: stall_d = 1'b0;
    endcase
  end

  // Output registers; reset clears them immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.csr_wr      <= 1'b0;
      bus.csr_addr    <= '0;
      bus.csr_wdata   <= '0;
      bus.stall       <= 1'b0;
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
    end else begin
      bus.csr_wr      <= wr_d;
      bus.csr_addr    <= addr_d;
      bus.csr_wdata   <= wdata_d;
      bus.stall       <= stall_d;
      bus.redirect    <= redir_d;
      bus.redirect_pc <= rpc_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: the driver acts as core and CSR file and
// pushes expected CSR writes/redirects; a monitor pops them as they appear.
module tb_trap_ctrl;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_ext = 1'b0;
  logic irq_timer = 1'b0;

  trap_if bus();

  trap_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_ext   (irq_ext),
    .irq_timer (irq_timer),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_redir;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_ev;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mcause = '0;
  logic        stall_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: output invariants every cycle, scoreboard pop on each action
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.csr_wr) begin
        chk("addr_idle_zero", 32'(bus.csr_addr), 32'h0);
        chk("wdata_idle_zero", bus.csr_wdata, 32'h0);
      end
      if (!bus.redirect) chk("rpc_idle_zero", bus.redirect_pc, 32'h0);
      if (bus.csr_wr || bus.redirect) begin
        chk("stall_busy", 32'(bus.stall), 32'h1);
        if (exp_q.size() == 0) begin
          chk("unexpected_action", 32'({bus.redirect, bus.csr_wr}), 32'h0);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("action_kind", 32'({bus.redirect, bus.csr_wr}), mon_ev.is_redir ? 32'h2 : 32'h1);
          if (mon_ev.is_redir) begin
            chk("redirect_pc", bus.redirect_pc, mon_ev.data);
          end else begin
            chk("csr_addr", 32'(bus.csr_addr), 32'(mon_ev.addr));
            chk("csr_wdata", bus.csr_wdata, mon_ev.data);
          end
        end
      end
    end
  end

  // One clock: advance to the falling edge and commit any CSR write
  task automatic cycle();
    @(negedge clk);
    if (bus.stall) stall_seen = 1'b1;
    if (!rst && bus.csr_wr) begin
      case (bus.csr_addr)
        12'h300: bus.csr_mstatus = bus.csr_wdata;
        12'h341: bus.csr_mepc    = bus.csr_wdata;
        12'h342: mcause          = bus.csr_wdata;
        default: ;
      endcase
    end
  endtask

  // Reference model: trap entry from the architectural rules
  task automatic model_trap(input bit ext, input bit tim, output bit taken);
    logic [31:0] ms, target;
    int          cause;
    bit          e_en, t_en;
    ms   = bus.csr_mstatus;
    e_en = ext && bus.csr_mie[11];
    t_en = tim && bus.csr_mie[7];
    taken = ms[3] && (e_en || t_en);
    if (taken) begin
      cause  = e_en ? 11 : 7;
      target = bus.csr_mtvec & ~32'h3;
      if (bus.csr_mtvec % 4 == 1) target = target + 32'(cause * 4);
      exp_q.push_back(ev_t'{1'b0, 12'h341, bus.pc});
      exp_q.push_back(ev_t'{1'b0, 12'h342, 32'h8000_0000 + 32'(cause)});
      exp_q.push_back(ev_t'{1'b0, 12'h300, (ms & ~32'h88) | 32'h80});
      exp_q.push_back(ev_t'{1'b1, 12'h000, target});
    end
  endtask

  // Reference model: MRET
  task automatic model_mret();
    logic [31:0] ms;
    ms = bus.csr_mstatus;
    exp_q.push_back(ev_t'{1'b0, 12'h300, (ms & ~32'h8) | (ms[7] ? 32'h8 : 32'h0) | 32'h80});
    exp_q.push_back(ev_t'{1'b1, 12'h000, bus.csr_mepc});
  endtask

  task automatic drain(input string name);
    chk(name, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic set_csr(input logic [31:0] ms, input logic [31:0] mie,
                         input logic [31:0] mtvec, input logic [31:0] pc);
    bus.csr_mstatus = ms;
    bus.csr_mie     = mie;
    bus.csr_mtvec   = mtvec;
    bus.pc          = pc;
  endtask

  task automatic run_trap(input bit ext, input bit tim);
    bit taken;
    model_trap(ext, tim, taken);
    stall_seen = 1'b0;
    irq_ext    = ext;
    irq_timer  = tim;
    repeat (16) cycle();
    if (!taken) chk("no_trap_stall", 32'(stall_seen), 32'h0);
    irq_ext   = 1'b0;
    irq_timer = 1'b0;
    repeat (8) cycle();
    drain("trap_drain");
  endtask

  task automatic run_mret(input logic [31:0] ms, input logic [31:0] mepc);
    bus.csr_mstatus = ms;
    bus.csr_mepc    = mepc;
    model_mret();
    cycle();
    bus.mret = 1'b1;
    cycle();
    bus.mret = 1'b0;
    chk("mret_lat_wr", 32'({bus.csr_wr, bus.stall}), 32'h3);
    cycle();
    chk("mret_lat_redirect", 32'(bus.redirect), 32'h1);
    repeat (8) cycle();
    drain("mret_drain");
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    bus.mret = 1'b0;
    bus.csr_mepc = '0;
    set_csr(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst_outputs", 32'({bus.csr_wr, bus.stall, bus.redirect}), 32'h0);
    chk("rst_addr_data", 32'(bus.csr_addr) | bus.csr_wdata | bus.redirect_pc, 32'h0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // External interrupt, direct mode
    set_csr(32'h8, 32'h800, 32'h100, 32'h40);
    run_trap(1'b1, 1'b0);
    chk("mcause_ext", mcause, 32'h8000_000B);

    // Timer interrupt, vectored mode
    set_csr(32'h8, 32'h80, 32'h101, 32'h40);
    run_trap(1'b0, 1'b1);
    chk("mcause_tmr", mcause, 32'h8000_0007);

    // Both pending: external wins
    set_csr(32'h8, 32'h880, 32'h200, 32'h1234);
    run_trap(1'b1, 1'b1);
    chk("mcause_prio", mcause, 32'h8000_000B);

    // Globally disabled: no trap
    set_csr(32'h0, 32'h880, 32'h200, 32'h1234);
    run_trap(1'b1, 1'b1);

    // MRET restores MIE
    run_mret(32'h80, 32'h44);
    chk("mret_mstatus", bus.csr_mstatus, 32'h88);

    // MRET coincident with a freshly pending interrupt
    set_csr(32'h88, 32'h800, 32'h300, 32'h50);
    bus.csr_mepc = 32'h60;
    model_mret();
    irq_ext = 1'b1;
    repeat (SYNC) cycle();
    bus.mret = 1'b1;
    irq_ext  = 1'b0;
    cycle();
    bus.mret = 1'b0;
    repeat (12) cycle();
    drain("mret_coincident");

    // Reset in T_CAUSE aborts the sequence
    set_csr(32'h8, 32'h800, 32'h200, 32'h80);
    model_trap(1'b1, 1'b0, found);
    irq_ext = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.csr_wr && bus.csr_addr == 12'h342) found = 1'b1;
    end
    chk("reach_t_cause", 32'(found), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", 32'({bus.csr_wr, bus.stall, bus.redirect}), 32'h0);
    chk("abort_addr_data", 32'(bus.csr_addr) | bus.csr_wdata | bus.redirect_pc, 32'h0);
    exp_q.delete();
    irq_ext = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    stall_seen = 1'b0;
    repeat (12) cycle();
    chk("abort_no_stall", 32'(stall_seen), 32'h0);
    drain("abort_drain");

    // Short timer pulse during T_STAT is not taken after return
    set_csr(32'h8, 32'h880, 32'h400, 32'h90);
    model_trap(1'b1, 1'b0, found);
    irq_ext = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.csr_wr && bus.csr_addr == 12'h300) found = 1'b1;
    end
    chk("reach_t_stat", 32'(found), 32'h1);
    irq_ext   = 1'b0;
    irq_timer = 1'b1;
    cycle();
    irq_timer = 1'b0;
    repeat (16) cycle();
    drain("pulse_drain");

    // Randomised traps and returns
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        run_mret($urandom, $urandom);
      end else begin
        set_csr($urandom, $urandom, $urandom, $urandom);
        run_trap(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of flip-flop stages that synchronise each interrupt input (legal 2..3).
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port irq_ext  input  1  asynchronous level external interrupt request.
REQ-005 SHALL have port irq_timer  input  1  asynchronous level timer interrupt request.
REQ-006 SHALL have port pc  input  32  PC of the instruction currently in execute.
REQ-007 SHALL have port mret  input  1  an MRET instruction is in execute (one-cycle qualifier).
REQ-008 SHALL have ports csr_mstatus, csr_mie, csr_mtvec, csr_mepc  input  32 each  current CSR file contents.
REQ-009 SHALL have port csr_wr  output  1  CSR write strobe toward the CSR file.
REQ-010 SHALL have port csr_addr  output  12  CSR address of the write.
REQ-011 SHALL have port csr_wdata  output  32  CSR write data.
REQ-012 SHALL have port stall  output  1  freeze fetch/decode/execute.
REQ-013 SHALL have port redirect  output  1  one-cycle PC redirect strobe.
REQ-014 SHALL have port redirect_pc  output  32  redirect target, valid when redirect=1.

Function
REQ-015 SHALL synchronise irq_ext and irq_timer through SYNC_STAGES flops each; raw inputs are never used directly.
REQ-016 Pending = (sync_ext & csr_mie[11]) | (sync_timer & csr_mie[7]), gated by csr_mstatus[3] (MIE).
REQ-017 Priority: external (cause 11) over timer (cause 7).
REQ-018 FSM states: IDLE, T_EPC, T_CAUSE, T_STAT, T_JMP, R_STAT, R_JMP.
REQ-019 IDLE: if mret=1 -> R_STAT (mret wins over a simultaneous pending interrupt); else if pending -> T_EPC, latching pc and cause; else stay.
REQ-020 T_EPC: csr_wr=1, csr_addr=0x341, csr_wdata=latched pc; -> T_CAUSE.
REQ-021 T_CAUSE: csr_wr=1, csr_addr=0x342, csr_wdata={1'b1, 27'b0, cause[3:0]}; -> T_STAT.
REQ-022 T_STAT: csr_wr=1, csr_addr=0x300, csr_wdata=csr_mstatus with bit7(MPIE)<=bit3, bit3(MIE)<=0; -> T_JMP.
REQ-023 T_JMP: redirect=1; redirect_pc={csr_mtvec[31:2],2'b00} if csr_mtvec[1:0]!=1, else {csr_mtvec[31:2],2'b00}+(cause<<2), 32-bit wrap; -> IDLE.
REQ-024 R_STAT: csr_wr=1, csr_addr=0x300, csr_wdata=csr_mstatus with bit3<=bit7, bit7<=1; -> R_JMP.
REQ-025 R_JMP: redirect=1, redirect_pc=csr_mepc; -> IDLE.
REQ-026 stall=1 in every state except IDLE; stall=0 in IDLE, including the detection cycle.
REQ-027 Entry latency: trap detected in IDLE cycle N -> redirect asserted in cycle N+4; mret in cycle N -> redirect in cycle N+2.
REQ-028 Interrupt changes or mret pulses while not in IDLE SHALL be ignored; a still-pending interrupt is re-evaluated only in IDLE.
REQ-029 After trap entry MIE=0, so no re-entry occurs until MRET restores it.
REQ-030 csr_wr and redirect SHALL never be high in the same cycle; csr_addr/csr_wdata SHALL be 0 when csr_wr=0, redirect_pc SHALL be 0 when redirect=0.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, clear synchroniser flops, latched pc and cause; outputs csr_wr=0, csr_addr=0, csr_wdata=0, stall=0, redirect=0, redirect_pc=0.
REQ-032 rst asserted mid-sequence SHALL abort it with no further CSR writes or redirect after release.

Verification
REQ-033 mie=0x800, mstatus=0x8, mtvec=0x100, pc=0x40, irq_ext=1 -> writes 0x341=0x40, 0x342=0x8000000B, 0x300=0x80, then redirect_pc=0x100.
REQ-034 Same but mtvec=0x101, irq_timer only, mie=0x80 -> cause 0x80000007, redirect_pc=0x11C.
REQ-035 irq_ext and irq_timer both high, both enabled -> cause 11 taken; mstatus MIE=0 -> no trap, stall stays 0.
REQ-036 mret with mstatus=0x80, mepc=0x44 -> write 0x300=0x88, next cycle redirect_pc=0x44; mret coincident with pending irq -> mret sequence only.
REQ-037 rst pulsed during T_CAUSE -> all outputs 0 immediately, FSM IDLE, no T_STAT write or redirect follows.
REQ-038 irq pulse shorter than SYNC_STAGES cycles while in T_STAT -> ignored, no second trap after return to IDLE.
